// File: rtl/mips_abb_pkg.sv
// Shared types and constants for the MIPS pipeline control blocks.
// Adds the scheduler state encoding and stage index constants.
package mips_abb_pkg;

  typedef logic [5:0]  stack;
  typedef logic [31:0] instr_addr;

  localparam logic      STOP   = 1'b1;
  localparam logic      NOSTOP = 1'b0;
  localparam logic      RESET  = 1'b0;
  localparam instr_addr ZERO   = 32'h0000_0000;

  localparam int STAGE_PC  = 0;
  localparam int STAGE_IF  = 1;
  localparam int STAGE_ID  = 2;
  localparam int STAGE_EX  = 3;
  localparam int STAGE_MEM = 4;
  localparam int STAGE_WB  = 5;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MC_BUSY = 2'd1,
    ST_MC_DONE = 2'd2,
    ST_FLUSH   = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/stall_mask_gen.sv
// Priority encoder: the highest stalled stage k freezes stages 0..k,
// so each stop bit is the OR of its own and all downstream requests.
module stall_mask_gen
  import mips_abb_pkg::*;
(
  input  stack stall_req,
  output stack stop_mask
);

  // Build the freeze mask from the stall requests
  always_comb begin
    stop_mask = {6{NOSTOP}};
    for (int k = 0; k < 6; k++) begin
      if (|(stall_req >> k)) begin
        stop_mask[k] = STOP;
      end else begin
        stop_mask[k] = NOSTOP;
      end
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline scheduler: merges stall requests, sequences multi-cycle EX ops
// and orders exception flushes. Optional perf counters: PIPE_STALL_PERF_EN.
module pipe_stall_ctrl
  import mips_abb_pkg::*;
#(
  parameter int MC_LEN_W = 6
) (
  input  logic                cpu_clk,
  input  logic                cpu_rst_n,
  input  logic                if_i_stallreq,
  input  logic                id_i_stallreq,
  input  logic                ex_i_mc_start,
  input  logic [MC_LEN_W-1:0] ex_i_mc_len,
  input  logic                mem_i_stallreq,
  input  logic                mem_i_flushreq,
  input  instr_addr           mem_i_flushpc,
  output stack                stop,
  output logic                flush,
  output instr_addr           flush_pc,
  output logic                ex_o_mc_done,
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_flush_cnt
);

  localparam logic [MC_LEN_W-1:0] LEN_ONE = MC_LEN_W'(1);
  localparam logic [MC_LEN_W-1:0] LEN_TWO = MC_LEN_W'(2);
  localparam logic [MC_LEN_W-1:0] LEN_ZERO = MC_LEN_W'(0);

  ctrl_state_e         state_r, state_nxt_s;
  logic [MC_LEN_W-1:0] mc_cnt_r, mc_cnt_nxt_s;
  instr_addr           flushpc_r, flushpc_nxt_s;
  stack                stall_req_s;

  stall_mask_gen u_mask (
    .stall_req (stall_req_s),
    .stop_mask (stop)
  );

  // State, countdown and handler-address registers
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (cpu_rst_n == RESET) begin
      state_r   <= ST_RUN;
      mc_cnt_r  <= LEN_ZERO;
      flushpc_r <= ZERO;
    end else begin
      state_r   <= state_nxt_s;
      mc_cnt_r  <= mc_cnt_nxt_s;
      flushpc_r <= flushpc_nxt_s;
    end
  end

  // Next-state, stall requests and pulse outputs
  always_comb begin
    state_nxt_s   = state_r;
    mc_cnt_nxt_s  = mc_cnt_r;
    flushpc_nxt_s = flushpc_r;
    stall_req_s   = 6'b00_0000;
    flush         = 1'b0;
    ex_o_mc_done  = 1'b0;

    if (state_r == ST_FLUSH) begin
      // Single flush pulse; any new flush request is dropped here
      flush       = 1'b1;
      state_nxt_s = ST_RUN;
    end else if (mem_i_flushreq) begin
      flushpc_nxt_s          = mem_i_flushpc;
      stall_req_s[STAGE_MEM] = 1'b1;
      mc_cnt_nxt_s           = LEN_ZERO;
      state_nxt_s            = ST_FLUSH;
    end else begin
      stall_req_s[STAGE_MEM] = mem_i_stallreq;
      stall_req_s[STAGE_ID]  = id_i_stallreq;
      stall_req_s[STAGE_IF]  = if_i_stallreq;
      case (state_r)
        ST_RUN: begin
          if (ex_i_mc_start && (ex_i_mc_len <= LEN_ONE)) begin
            ex_o_mc_done = 1'b1;
          end else if (ex_i_mc_start && !mem_i_stallreq) begin
            stall_req_s[STAGE_EX] = 1'b1;
            mc_cnt_nxt_s          = ex_i_mc_len - LEN_TWO;
            if (ex_i_mc_len == LEN_TWO) begin
              state_nxt_s = ST_MC_DONE;
            end else begin
              state_nxt_s = ST_MC_BUSY;
            end
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_MC_BUSY: begin
          stall_req_s[STAGE_EX] = 1'b1;
          if (mc_cnt_r > LEN_ONE) begin
            mc_cnt_nxt_s = mc_cnt_r - LEN_ONE;
          end else begin
            mc_cnt_nxt_s = LEN_ZERO;
            state_nxt_s  = ST_MC_DONE;
          end
        end
        ST_MC_DONE: begin
          ex_o_mc_done = 1'b1;
          if (mem_i_stallreq) begin
            state_nxt_s = ST_MC_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        default: begin
          state_nxt_s = ST_RUN;
        end
      endcase
    end
  end

  assign flush_pc = flushpc_r;

`ifdef PIPE_STALL_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;

  // Saturating stall-cycle and flush-entry counters
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (cpu_rst_n == RESET) begin
      stall_cnt_r <= 32'h0000_0000;
      flush_cnt_r <= 32'h0000_0000;
    end else begin
      if ((stop[STAGE_PC] == STOP) && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if ((state_nxt_s == ST_FLUSH) && (state_r != ST_FLUSH) &&
          (flush_cnt_r != 32'hFFFF_FFFF)) begin
        flush_cnt_r <= flush_cnt_r + 32'h0000_0001;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_r;
  assign perf_flush_cnt = flush_cnt_r;
`else
  assign perf_stall_cnt = 32'h0000_0000;
  assign perf_flush_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: per-cycle expectations are queued
// when stimulus is driven and compared against the DUT mid-cycle.
module tb_pipe_stall_ctrl;

  typedef struct {
    logic [5:0]  stop;
    logic        flush;
    logic        done;
    logic [31:0] pc;
  } exp_t;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst_n = 1'b0;
  logic        if_i_stallreq = 1'b0;
  logic        id_i_stallreq = 1'b0;
  logic        ex_i_mc_start = 1'b0;
  logic [5:0]  ex_i_mc_len = 6'd0;
  logic        mem_i_stallreq = 1'b0;
  logic        mem_i_flushreq = 1'b0;
  logic [31:0] mem_i_flushpc = 32'h0;
  logic [5:0]  stop;
  logic        flush;
  logic [31:0] flush_pc;
  logic        ex_o_mc_done;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_pc = 32'h0;
  int          model_stalls = 0;
  int          model_flushes = 0;

  pipe_stall_ctrl #(.MC_LEN_W(6)) dut (
    .cpu_clk        (cpu_clk),
    .cpu_rst_n      (cpu_rst_n),
    .if_i_stallreq  (if_i_stallreq),
    .id_i_stallreq  (id_i_stallreq),
    .ex_i_mc_start  (ex_i_mc_start),
    .ex_i_mc_len    (ex_i_mc_len),
    .mem_i_stallreq (mem_i_stallreq),
    .mem_i_flushreq (mem_i_flushreq),
    .mem_i_flushpc  (mem_i_flushpc),
    .stop           (stop),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .ex_o_mc_done   (ex_o_mc_done),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    cpu_rst_n      = 1'b0;
    if_i_stallreq  = 1'b0;
    id_i_stallreq  = 1'b0;
    ex_i_mc_start  = 1'b0;
    ex_i_mc_len    = 6'd0;
    mem_i_stallreq = 1'b0;
    mem_i_flushreq = 1'b0;
    mem_i_flushpc  = 32'h0;
    repeat (2) @(negedge cpu_clk);
    cpu_rst_n     = 1'b1;
    model_pc      = 32'h0;
    model_stalls  = 0;
    model_flushes = 0;
  endtask

  // One clock of stimulus plus the outputs expected during that clock
  task automatic cyc(input string tag,
                     input logic i_if, input logic i_id, input logic i_mcs,
                     input logic [5:0] i_len, input logic i_mst,
                     input logic i_mfl, input logic [31:0] i_mpc,
                     input logic [5:0] e_stop, input logic e_flush, input logic e_done);
    exp_t e;
    exp_t got;
    @(posedge cpu_clk);
    #1;
    if_i_stallreq  = i_if;
    id_i_stallreq  = i_id;
    ex_i_mc_start  = i_mcs;
    ex_i_mc_len    = i_len;
    mem_i_stallreq = i_mst;
    mem_i_flushreq = i_mfl;
    mem_i_flushpc  = i_mpc;
    e.stop  = e_stop;
    e.flush = e_flush;
    e.done  = e_done;
    e.pc    = model_pc;
    sb_q.push_back(e);
    model_stalls  += int'(e_stop[0]);
    model_flushes += int'(e_flush);
    if (i_mfl && !e_flush) begin
      model_pc = i_mpc;
    end
    @(negedge cpu_clk);
    got = sb_q.pop_front();
    check_eq({tag, ".stop"},  64'(stop),         64'(got.stop));
    check_eq({tag, ".flush"}, 64'(flush),        64'(got.flush));
    check_eq({tag, ".done"},  64'(ex_o_mc_done), 64'(got.done));
    check_eq({tag, ".pc"},    64'(flush_pc),     64'(got.pc));
  endtask

  initial begin
    do_reset();
    #1;
    check_eq("rst.stop",  64'(stop),           64'h0);
    check_eq("rst.flush", 64'(flush),          64'h0);
    check_eq("rst.done",  64'(ex_o_mc_done),   64'h0);
    check_eq("rst.pc",    64'(flush_pc),       64'h0);
    check_eq("rst.pstl",  64'(perf_stall_cnt), 64'h0);
    check_eq("rst.pfl",   64'(perf_flush_cnt), 64'h0);

    // Reset in the middle of a multi-cycle op aborts it asynchronously
    cyc("arst_start", 1'b0, 1'b0, 1'b1, 6'd6, 1'b0, 1'b0, 32'h0, 6'b001111, 1'b0, 1'b0);
    @(posedge cpu_clk);
    #1 ex_i_mc_start = 1'b0;
    #2 cpu_rst_n = 1'b0;
    #1;
    check_eq("arst.stop", 64'(stop),         64'h0);
    check_eq("arst.done", 64'(ex_o_mc_done), 64'h0);
    do_reset();

    cyc("idle",    1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b0);
    cyc("id",      1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 6'b000111, 1'b0, 1'b0);
    cyc("id_end",  1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b0);
    cyc("if",      1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 6'b000011, 1'b0, 1'b0);
    cyc("if_id",   1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 6'b000111, 1'b0, 1'b0);
    cyc("mem",     1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0, 6'b011111, 1'b0, 1'b0);

    // len = 5: four stalled cycles, done in cycle 5, back to RUN in cycle 6
    cyc("mc5_c1",  1'b0, 1'b0, 1'b1, 6'd5, 1'b0, 1'b0, 32'h0, 6'b001111, 1'b0, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      cyc($sformatf("mc5_c%0d", i), 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 6'b001111, 1'b0, 1'b0);
    end
    cyc("mc5_c5",  1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b1);
    cyc("mc5_c6",  1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b0);

    // len = 4 with MEM stalling in cycles 3..6
    cyc("mc4_c1",  1'b0, 1'b0, 1'b1, 6'd4, 1'b0, 1'b0, 32'h0, 6'b001111, 1'b0, 1'b0);
    cyc("mc4_c2",  1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 6'b001111, 1'b0, 1'b0);
    cyc("mc4_c3",  1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0, 6'b011111, 1'b0, 1'b0);
    for (int i = 4; i <= 6; i++) begin
      cyc($sformatf("mc4_c%0d", i), 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0, 6'b011111, 1'b0, 1'b1);
    end
    cyc("mc4_c7",  1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b1);
    cyc("mc4_c8",  1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b0);

    // Flush during MC_BUSY; a second request during the flush pulse is dropped
    cyc("fl_c1",   1'b0, 1'b0, 1'b1, 6'd6, 1'b0, 1'b0, 32'h0, 6'b001111, 1'b0, 1'b0);
    cyc("fl_c2",   1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 6'b001111, 1'b0, 1'b0);
    cyc("fl_req",  1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 32'hBFC0_0380, 6'b011111, 1'b0, 1'b0);
    cyc("fl_puls", 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 32'h1234_5678, 6'b000000, 1'b1, 1'b0);
    cyc("fl_run",  1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b0);
    cyc("fl_run2", 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b0);

    // Short ops complete in the start cycle without stalling
    cyc("len0",    1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b1);
    cyc("len0_n",  1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b0);
    cyc("len1",    1'b0, 1'b0, 1'b1, 6'd1, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b1);
    cyc("len1_n",  1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b0);
    cyc("len2_c1", 1'b0, 1'b0, 1'b1, 6'd2, 1'b0, 1'b0, 32'h0, 6'b001111, 1'b0, 1'b0);
    cyc("len2_c2", 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b1);
    cyc("len2_c3", 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b0);

    @(posedge cpu_clk);
    #1;
`ifdef PIPE_STALL_PERF_EN
    check_eq("perf_stall", 64'(perf_stall_cnt), 64'(model_stalls));
    check_eq("perf_flush", 64'(perf_flush_cnt), 64'(model_flushes));
`else
    check_eq("perf_stall", 64'(perf_stall_cnt), 64'h0);
    check_eq("perf_flush", 64'(perf_flush_cnt), 64'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central pipeline scheduler for the five-stage MIPS core. Merges stall requests from IF, ID, EX and MEM, sequences multi-cycle EX operations with an internal countdown, and orders exception flushes. Drives the shared 6-bit `stop` vector consumed by the PC register and by every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
Parameters:
- `MC_LEN_W`, default 6: width of the multi-cycle length field.

Ports:
- `cpu_clk` in 1: core clock.
- `cpu_rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `if_i_stallreq` in 1: fetch wait (instruction bus not ready).
- `id_i_stallreq` in 1: load-use hazard.
- `ex_i_mc_start` in 1: EX issues a multi-cycle op this cycle.
- `ex_i_mc_len` in `MC_LEN_W`: total op latency in cycles, N.
- `mem_i_stallreq` in 1: data bus wait.
- `mem_i_flushreq` in 1: exception taken in MEM.
- `mem_i_flushpc` in 32 (`instr_addr`): handler address.
- `stop` out 6 (`stack`): index 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB.
- `flush` out 1: clear all pipeline registers.
- `flush_pc` out 32 (`instr_addr`): PC to load while `flush` = 1.
- `ex_o_mc_done` out 1: multi-cycle result valid in EX.
- `perf_stall_cnt` out 32: stall-cycle counter.
- `perf_flush_cnt` out 32: flush counter.

## Operation
- Stall rule: the highest stalled stage k sets `stop[0..k]` = STOP and `stop[k+1..5]` = NOSTOP. A downstream register that sees its upstream stalled while itself running inserts a bubble.
- Source priority, highest first: flush request, MEM, multi-cycle EX, ID, IF.
- FSM states: RUN, MC_BUSY, MC_DONE, FLUSH.
  - **RUN**, `ex_i_mc_start` with N ≥ 2 and `stop[3]` not otherwise forced: load counter = N−2, go to MC_BUSY, assert `stop[0..3]`.
  - **RUN**, N ≤ 1: `ex_o_mc_done` asserts the same cycle. No stall and no state change.
  - **MC_BUSY**: `stop[0..3]` = STOP. Counter decrements every cycle, including during MEM stalls. At counter = 0 go to MC_DONE.
  - **MC_DONE**: `ex_o_mc_done` = 1. EX is released unless MEM stalls. Return to RUN when `stop[3]` = NOSTOP. If MEM is stalling, hold MC_DONE with done held high.
  - **Any state** with `mem_i_flushreq`: latch `mem_i_flushpc`, drive `stop[0..4]` = STOP and `stop[5]` = NOSTOP (bubble into WB), next state FLUSH. Any multi-cycle op in progress is aborted.
  - **FLUSH**: exactly one cycle. `flush` = 1, `flush_pc` = latched PC, all `stop` = NOSTOP. Next state RUN. A `mem_i_flushreq` arriving during FLUSH is ignored.
- Counter is `MC_LEN_W` bits, unsigned, with no wrap. N = 0 is treated as N = 1.

## Timing
- `stop`, `ex_o_mc_done` and `flush` are combinational from the inputs and registered state, so they take effect in the same cycle.
- Multi-cycle op of N ≥ 2 with no MEM stall: the start cycle plus N−2 MC_BUSY cycles gives N−1 stalled cycles. `ex_o_mc_done` asserts in cycle N.
- Flush latency: request cycle, then `flush` pulse in the next cycle, then normal fetch from `flush_pc` after that.
- Reset values: state RUN, counter 0, latched PC 0, `stop` = all NOSTOP, `flush` = 0, `flush_pc` = 0, `ex_o_mc_done` = 0, both perf counters 0.
- Reset asserted mid-operation aborts MC and FLUSH immediately and asynchronously.

## Configuration
- Macro: `PIPE_STALL_PERF_EN`.
- Defined: `perf_stall_cnt` increments on every cycle where `stop[0]` = STOP. `perf_flush_cnt` increments on each FLUSH entry. Both counters saturate at 2^32−1.
- Undefined: both outputs are tied to 0 and no counter flops are built. Ports remain present.

## Structure
- Shared items go in `mips_abb_pkg`:
  - existing: `stack`, `STOP`, `NOSTOP`, `RESET`, `instr_addr`, `ZERO`;
  - new: a `ctrl_state_e` enum and a `STAGE_PC` … `STAGE_WB` index constants.
- One sub-module, `stall_mask_gen`: a combinational priority encoder that maps the highest stalled stage to a `stack` mask.

## Test plan
- `id_i_stallreq` = 1 for one cycle → `stop` = 6'b000111 for that cycle, then 6'b000000.
- `ex_i_mc_start` with len = 5, no other requests → `stop[0..3]` STOP for 4 cycles, `ex_o_mc_done` in cycle 5, RUN in cycle 6.
- len = 4 with `mem_i_stallreq` spanning cycles 3–6 → `stop` = 6'b011111 in cycles 3–6, `ex_o_mc_done` held in cycles 4–6, release in cycle 7.
- `mem_i_flushreq` with flushpc = 0xBFC00380 in MC_BUSY → `stop` = 6'b011111, next cycle `flush` = 1 with `flush_pc` = 0xBFC00380 and `ex_o_mc_done` never asserted.
- len = 0 and len = 1 → `ex_o_mc_done` in the start cycle, zero stall cycles.
- With `PIPE_STALL_PERF_EN`: 3 stall cycles plus 1 flush → counters read 3 and 1. Without it, both read 0.
